data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter MEM_SIZE, default 1024, SHALL set memory depth in 32-bit words; AW = $clog2(MEM_SIZE).
REQ-002 Parameter DATA_WIDTH, default 32 (pkg_config), SHALL set the data width.
REQ-003 One clock and one reset: reset is asynchronous and active-low. Ports SHALL be:
REQ-004 clk_i  in  1  system clock, all state updates on rising edge
REQ-005 rst_ni  in  1  asynchronous active-low reset
REQ-006 core_req_i  in  1  core load/store request
REQ-007 core_we_i  in  1  1 = store, 0 = load
REQ-008 core_addr_i  in  32  byte address; bits above AW+1 ignored
REQ-009 core_funct3_i  in  3  RV32I size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
REQ-010 core_wdata_i  in  32  store data, right-aligned
REQ-011 core_gnt_o / core_rvalid_o / core_err_o  out  1 each  grant, response valid, misaligned error
REQ-012 core_rdata_o  out  32  extended load data
REQ-013 dbg_req_i, dbg_we_i  in  1 each; dbg_addr_i  in  AW  word address; dbg_wdata_i  in  32
REQ-014 dbg_gnt_o, dbg_rvalid_o  out  1 each; dbg_rdata_o  out  32  (word-only port)
REQ-015 mem_we_o  out  1; mem_addr_o  out  AW; mem_data_o  out  32; mem_data_i  in  32 (valid one cycle after mem_addr_o)

Function
REQ-016 FSM states SHALL be IDLE, LD_WAIT, RMW_WAIT; requests SHALL be granted only in IDLE, at most one grant per cycle.
REQ-017 Arbitration SHALL be round-robin: both requesting -> grant port not granted last; single requester -> granted directly.
REQ-018 Grant is combinational in the request cycle T; address, data and type SHALL be latched at T.
REQ-019 Load (either port): mem_addr_o driven at T, IDLE->LD_WAIT; at T+1 capture mem_data_i; rvalid pulse one cycle at T+2 in IDLE.
REQ-020 Core load extraction: byte/half selected by addr[1:0]/addr[1]; 000/001 sign-extend, 100/101 zero-extend.
REQ-021 Word store (SW or debug write): mem_we_o=1 at T, stays IDLE; rvalid pulse at T+1, rdata 0.
REQ-022 SB/SH: read at T -> RMW_WAIT; at T+1 merge wdata lanes into mem_data_i, mem_we_o=1 same address; rvalid at T+2.
REQ-023 Undefined funct3 (011, 110, 111) SHALL be treated as word access.
REQ-024 Earliest next grant after load or sub-word store: T+2 (concurrent with rvalid); after word store: T+1.
REQ-025 rvalid SHALL go only to the port that was granted; other port's rvalid stays 0.
REQ-026 mem_we_o SHALL be 0 in all cycles except REQ-021/REQ-022 write cycles.

Reset
REQ-027 rst_ni low SHALL immediately force: state IDLE, mem_we_o 0, all gnt/rvalid/err 0, rdata 0, mem_addr_o 0, last-grant = dbg (core wins first tie).
REQ-028 Reset mid-transaction SHALL drop the transaction: no pending RMW write, no rvalid after release.

Configuration
REQ-029 With DMEM_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 SHALL be granted, make no memory access, and pulse core_rvalid_o with core_err_o=1 at T+1.
REQ-030 Without DMEM_MISALIGN_TRAP_EN: misaligned addresses SHALL be aligned down silently; core_err_o tied 0.

Verification
REQ-031 Mem word 2 = 0x8000_00F1; core LB addr 0x8 -> core_rvalid_o at T+2, rdata 0xFFFF_FFF1; LBU -> 0x0000_00F1.
REQ-032 Mem word 1 = 0x1122_3344; core SB addr 0x6 wdata 0xAB -> mem_we_o at T+1 writing 0x11AB_3344; rvalid at T+2.
REQ-033 core and dbg request same cycle from reset -> core granted first, dbg granted at next IDLE; dbg_rvalid_o never overlaps core_rvalid_o.
REQ-034 Core LW addr 0x6: with DMEM_MISALIGN_TRAP_EN -> err=1 at T+1, mem_we_o 0; without -> reads word 1, err 0.
REQ-035 Assert rst_ni low in RMW_WAIT of SH addr 0x2 -> word 0 unchanged, no rvalid after release, next core request granted.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: core, debug and memory-side signals of the data memory controller
interface data_mem_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic core_req_i, core_we_i;
  logic [31:0] core_addr_i;
  logic [2:0] core_funct3_i;
  logic [DW-1:0] core_wdata_i;
  logic core_gnt_o, core_rvalid_o, core_err_o;
  logic [DW-1:0] core_rdata_o;
  logic dbg_req_i, dbg_we_i;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_wdata_i;
  logic dbg_gnt_o, dbg_rvalid_o;
  logic [DW-1:0] dbg_rdata_o;
  logic mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, mem_data_i;
  modport slave (
    input core_req_i, core_we_i, core_addr_i, core_funct3_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_err_o, core_rdata_o,
    input dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output mem_we_o, mem_addr_o, mem_data_o,
    input mem_data_i
  );
  modport master (
    output core_req_i, core_we_i, core_addr_i, core_funct3_i, core_wdata_i,
    input core_gnt_o, core_rvalid_o, core_err_o, core_rdata_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input mem_we_o, mem_addr_o, mem_data_o,
    output mem_data_i
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: round-robin core/debug data memory controller with sub-word RMW; DMEM_MISALIGN_TRAP_EN enables misalignment traps
module data_mem_ctrl #(
  parameter int MEM_SIZE = 1024,
  parameter int DATA_WIDTH = 32
) (
  input logic clk_i,
  input logic rst_ni,
  data_mem_ctrl_if.slave bus
);
  localparam int AW = $clog2(MEM_SIZE);
  typedef enum logic [1:0] {IDLE, LD_WAIT, RMW_WAIT} state_t;
  state_t state, state_n;
  logic last_dbg, port_q, uns_q, rv_q, g_core, g_dbg, grant, mis, one_cyc, we_now, ld_now, unused_ok;
  logic [1:0] sz_q, off_q, c_sz;
  logic [4:0] sh;
  logic [AW-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, shifted, mask, ext;
  assign unused_ok = ^bus.core_addr_i[31:AW+2];
  // sizes: 0 byte, 1 half, 2 word; undefined funct3 codes fall into word
  assign c_sz = bus.core_funct3_i[1:0] == 2'd0 ? 2'd0 : bus.core_funct3_i[1:0] == 2'd1 ? 2'd1 : 2'd2;
  assign g_core = state == IDLE && rst_ni && bus.core_req_i && (!bus.dbg_req_i || last_dbg);
  assign g_dbg = state == IDLE && rst_ni && bus.dbg_req_i && !g_core;
  assign grant = g_core || g_dbg;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;
  assign mis = (c_sz == 2'd1 && bus.core_addr_i[0]) || (c_sz == 2'd2 && bus.core_addr_i[1:0] != 2'd0);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) err_q <= 1'b0;
    else err_q <= g_core && mis;
  assign bus.core_err_o = bus.core_rvalid_o && err_q;
`else
  assign mis = 1'b0;
  assign bus.core_err_o = 1'b0;
`endif
  assign addr_n = g_dbg ? bus.dbg_addr_i : bus.core_addr_i[AW+1:2];
  assign we_now = g_dbg ? bus.dbg_we_i : bus.core_we_i && c_sz == 2'd2 && !mis;
  assign ld_now = g_dbg ? !bus.dbg_we_i : !bus.core_we_i && !mis;
  assign one_cyc = g_dbg ? bus.dbg_we_i : mis || (bus.core_we_i && c_sz == 2'd2);
  always_comb begin
    state_n = IDLE;
    if (state == IDLE && grant && !one_cyc) state_n = ld_now ? LD_WAIT : RMW_WAIT;
  end
  assign sh = sz_q == 2'd0 ? {off_q, 3'b0} : {off_q[1], 4'b0};
  assign shifted = bus.mem_data_i >> sh;
  assign mask = (sz_q == 2'd0 ? 32'hFF : 32'hFFFF) << sh;
  assign ext = sz_q == 2'd0 ? {{24{!uns_q && shifted[7]}}, shifted[7:0]} :
               sz_q == 2'd1 ? {{16{!uns_q && shifted[15]}}, shifted[15:0]} : bus.mem_data_i;
  assign bus.core_gnt_o = g_core;
  assign bus.dbg_gnt_o = g_dbg;
  assign bus.mem_we_o = (grant && we_now) || state == RMW_WAIT;
  assign bus.mem_addr_o = grant ? addr_n : addr_q;
  assign bus.mem_data_o = state == RMW_WAIT ? (bus.mem_data_i & ~mask) | ((wdata_q << sh) & mask) :
                          g_dbg ? bus.dbg_wdata_i : bus.core_wdata_i;
  assign bus.core_rvalid_o = rv_q && !port_q;
  assign bus.dbg_rvalid_o = rv_q && port_q;
  assign bus.core_rdata_o = bus.core_rvalid_o ? rdata_q : '0;
  assign bus.dbg_rdata_o = bus.dbg_rvalid_o ? rdata_q : '0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      last_dbg <= 1'b1;
      port_q <= 1'b0;
      uns_q <= 1'b0;
      rv_q <= 1'b0;
      sz_q <= 2'd0;
      off_q <= 2'd0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      rv_q <= state != IDLE || (grant && one_cyc);
      rdata_q <= state == LD_WAIT ? ext : '0;
      if (grant) begin
        last_dbg <= g_dbg;
        port_q <= g_dbg;
        addr_q <= addr_n;
        off_q <= g_dbg ? 2'd0 : bus.core_addr_i[1:0];
        sz_q <= g_dbg ? 2'd2 : c_sz;
        uns_q <= bus.core_funct3_i[2];
        wdata_q <= g_dbg ? bus.dbg_wdata_i : bus.core_wdata_i;
      end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized bench for data_mem_ctrl against a byte-level memory reference model
module tb_data_mem_ctrl;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  data_mem_ctrl_if #(.AW(10), .DW(32)) bus ();
  data_mem_ctrl dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus.slave));
  always #5 clk_i = ~clk_i;
  logic [31:0] env_mem [0:1023];
  logic [31:0] ref_mem [0:15];
  logic [31:0] last_rd;
  logic last_err;
  int n_chk = 0, n_fail = 0;
  always @(posedge clk_i) begin
    if (bus.mem_we_o) env_mem[bus.mem_addr_o] <= bus.mem_data_o;
    bus.mem_data_i <= env_mem[bus.mem_addr_o];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle_inputs;
    bus.core_req_i = 1'b0;
    bus.core_we_i = 1'b0;
    bus.core_addr_i = '0;
    bus.core_funct3_i = '0;
    bus.core_wdata_i = '0;
    bus.dbg_req_i = 1'b0;
    bus.dbg_we_i = 1'b0;
    bus.dbg_addr_i = '0;
    bus.dbg_wdata_i = '0;
  endtask
  task automatic do_reset;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    bus.core_req_i = 1'b1;
    bus.dbg_req_i = 1'b1;
    bus.core_we_i = 1'b1;
    bus.dbg_we_i = 1'b1;
    #1;
    check("rst_gnt", 32'({bus.core_gnt_o, bus.dbg_gnt_o}), 0);
    check("rst_rvalid", 32'({bus.core_rvalid_o, bus.dbg_rvalid_o}), 0);
    check("rst_we", 32'(bus.mem_we_o), 0);
    check("rst_addr", 32'(bus.mem_addr_o), 0);
    check("rst_err", 32'(bus.core_err_o), 0);
    check("rst_rdata", bus.core_rdata_o | bus.dbg_rdata_o, 0);
    @(posedge clk_i);
    #1;
    idle_inputs();
    rst_ni = 1'b1;
  endtask
  // One transaction on one port; expectations come from byte-lane arithmetic on ref_mem.
  task automatic op(input bit dbg, input bit we, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
    int w, sz, o, lat, wr_cyc, wr_n, other_rv, exp_lat, exp_we;
    bit trap;
    logic [31:0] nw, exp_rd;
    w = dbg ? int'(addr[3:0]) : int'(addr[5:2]);
    sz = dbg ? 4 : (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    o = dbg ? 0 : int'(addr[1:0]);
    trap = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = !dbg && (o % sz != 0);
`endif
    o = o - o % sz;
    exp_rd = '0;
    exp_we = 99;
    if (trap) exp_lat = 1;
    else if (we) begin
      nw = ref_mem[w];
      for (int b = 0; b < sz; b++) nw[8*(o+b) +: 8] = wd[8*b +: 8];
      ref_mem[w] = nw;
      exp_lat = sz == 4 ? 1 : 2;
      exp_we = sz == 4 ? 0 : 1;
    end else begin
      for (int b = 0; b < sz; b++) exp_rd[8*b +: 8] = ref_mem[w][8*(o+b) +: 8];
      if (!f3[2] && sz < 4)
        for (int b = sz; b < 4; b++) exp_rd[8*b +: 8] = {8{exp_rd[8*sz-1]}};
      exp_lat = 2;
    end
    @(posedge clk_i);
    #1;
    if (dbg) begin
      bus.dbg_req_i = 1'b1;
      bus.dbg_we_i = we;
      bus.dbg_addr_i = addr[9:0];
      bus.dbg_wdata_i = wd;
    end else begin
      bus.core_req_i = 1'b1;
      bus.core_we_i = we;
      bus.core_addr_i = addr;
      bus.core_funct3_i = f3;
      bus.core_wdata_i = wd;
    end
    @(negedge clk_i);
    check("gnt", 32'({bus.core_gnt_o, bus.dbg_gnt_o}), dbg ? 32'd1 : 32'd2);
    wr_cyc = 99;
    wr_n = 0;
    if (bus.mem_we_o) begin
      wr_cyc = 0;
      wr_n++;
    end
    @(posedge clk_i);
    #1;
    bus.core_req_i = 1'b0;
    bus.dbg_req_i = 1'b0;
    lat = 0;
    other_rv = 0;
    last_rd = 'x;
    last_err = 'x;
    for (int c = 1; c <= 4 && lat == 0; c++) begin
      @(negedge clk_i);
      if (bus.mem_we_o) begin
        if (wr_n == 0) wr_cyc = c;
        wr_n++;
      end
      if (dbg ? bus.core_rvalid_o : bus.dbg_rvalid_o) other_rv++;
      if (dbg ? bus.dbg_rvalid_o : bus.core_rvalid_o) begin
        lat = c;
        last_rd = dbg ? bus.dbg_rdata_o : bus.core_rdata_o;
        last_err = bus.core_err_o;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rdata", last_rd, exp_rd);
    check("err", 32'(last_err), 32'(trap));
    check("we_cycle", 32'(wr_cyc), 32'(exp_we));
    check("we_count", 32'(wr_n), exp_we == 99 ? 32'd0 : 32'd1);
    check("other_rvalid", 32'(other_rv), 0);
    check("mem_word", env_mem[w], ref_mem[w]);
  endtask
  initial begin
    int seen;
    bit d;
    idle_inputs();
    #3;
    do_reset();
    for (int i = 0; i < 16; i++) op(1'b1, 1'b1, 32'(i), 3'd2, $urandom);
    do_reset();
    // simultaneous requests straight out of reset: core first, dbg at the next IDLE
    @(posedge clk_i);
    #1;
    bus.core_req_i = 1'b1;
    bus.core_addr_i = 32'h8;
    bus.core_funct3_i = 3'd2;
    bus.dbg_req_i = 1'b1;
    bus.dbg_addr_i = 10'd1;
    @(negedge clk_i);
    check("tie_gnt", 32'({bus.core_gnt_o, bus.dbg_gnt_o}), 32'd2);
    @(posedge clk_i);
    #1;
    bus.core_req_i = 1'b0;
    @(negedge clk_i);
    check("tie_t1", 32'({bus.dbg_gnt_o, bus.core_rvalid_o, bus.dbg_rvalid_o}), 0);
    @(negedge clk_i);
    check("tie_t2", 32'({bus.dbg_gnt_o, bus.core_rvalid_o, bus.dbg_rvalid_o}), 32'd6);
    check("tie_core_rdata", bus.core_rdata_o, ref_mem[2]);
    @(posedge clk_i);
    #1;
    bus.dbg_req_i = 1'b0;
    @(negedge clk_i);
    check("tie_t3", 32'({bus.core_rvalid_o, bus.dbg_rvalid_o}), 0);
    @(negedge clk_i);
    check("tie_t4", 32'({bus.core_rvalid_o, bus.dbg_rvalid_o}), 32'd1);
    check("tie_dbg_rdata", bus.dbg_rdata_o, ref_mem[1]);
    op(1'b0, 1'b0, 32'h0, 3'd2, 0);
    @(posedge clk_i);
    #1;
    bus.core_req_i = 1'b1;
    bus.dbg_req_i = 1'b1;
    bus.dbg_addr_i = 10'd3;
    @(negedge clk_i);
    check("rr_gnt", 32'({bus.core_gnt_o, bus.dbg_gnt_o}), 32'd1);
    @(posedge clk_i);
    #1;
    idle_inputs();
    repeat (3) @(negedge clk_i);
    op(1'b1, 1'b1, 32'd2, 3'd2, 32'h8000_00F1);
    op(1'b0, 1'b0, 32'h8, 3'd0, 0);
    check("lb_sext", last_rd, 32'hFFFF_FFF1);
    op(1'b0, 1'b0, 32'h8, 3'd4, 0);
    check("lbu_zext", last_rd, 32'h0000_00F1);
    op(1'b1, 1'b1, 32'd1, 3'd2, 32'h1122_3344);
    op(1'b0, 1'b1, 32'h6, 3'd0, 32'hAB);
    check("sb_merge", env_mem[1], 32'h11AB_3344);
    op(1'b0, 1'b0, 32'h6, 3'd2, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lw_mis_err", 32'(last_err), 32'd1);
`else
    check("lw_mis_rdata", last_rd, 32'h11AB_3344);
`endif
    // reset while the sub-word store waits for its read data
    op(1'b1, 1'b1, 32'd0, 3'd2, 32'h5566_7788);
    @(posedge clk_i);
    #1;
    bus.core_req_i = 1'b1;
    bus.core_we_i = 1'b1;
    bus.core_addr_i = 32'h2;
    bus.core_funct3_i = 3'd1;
    bus.core_wdata_i = 32'hBEEF;
    @(negedge clk_i);
    check("rmw_rst_gnt", 32'(bus.core_gnt_o), 32'd1);
    @(posedge clk_i);
    #1;
    idle_inputs();
    rst_ni = 1'b0;
    #1;
    check("rmw_rst_we", 32'(bus.mem_we_o), 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (bus.core_rvalid_o || bus.dbg_rvalid_o) seen++;
    end
    check("rmw_rst_norv", 32'(seen), 0);
    check("rmw_rst_mem", env_mem[0], 32'h5566_7788);
    op(1'b0, 1'b0, 32'h0, 3'd2, 0);
    for (int i = 0; i < 300; i++) begin
      d = ($urandom % 4) == 0;
      op(d, 1'($urandom % 2), d ? $urandom % 16 : $urandom % 64, 3'($urandom % 8), $urandom);
    end
    for (int i = 0; i < 16; i++) check("final_mem", env_mem[i], ref_mem[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
